// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot gate: phase-FSM state encodings,
// beam pattern constants (written as {a,b}), direction codes and the default
// lot capacity. The gate detector decodes against the same AB and direction
// constants, so the two sides cannot drift apart.
package parking_pkg;

   localparam int CAPACITY_DEFAULT = 16;

   localparam logic DIR_ENTER = 1'b0;
   localparam logic DIR_EXIT  = 1'b1;

   localparam logic [1:0] AB_IDLE = 2'b00;
   localparam logic [1:0] AB_10   = 2'b10;
   localparam logic [1:0] AB_11   = 2'b11;
   localparam logic [1:0] AB_01   = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      PH1,
      PH2,
      PH3,
      GAP
   } state_t;

   // Beam pattern shown while in a given phase. Enter breaks the outer beam
   // first, exit the inner one; PH2 is always both beams blocked, so every
   // transition flips exactly one line.
   function automatic logic [1:0] phase_ab(input logic dir, input state_t phase);
      logic [1:0] ab;
      ab = AB_IDLE;
      case (phase)
         PH1:     ab = (dir == DIR_ENTER) ? AB_10 : AB_01;
         PH2:     ab = AB_11;
         PH3:     ab = (dir == DIR_ENTER) ? AB_01 : AB_10;
         default: ab = AB_IDLE;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating up/down occupancy counter with full/empty flags.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears count)
//   inc, dec    - one-cycle requests to add / remove a car
//   count       - current occupancy, 0..CAPACITY
//   full, empty - count == CAPACITY / count == 0
module parking_occupancy_counter
   import parking_pkg::*;
#(
   parameter int CAPACITY = CAPACITY_DEFAULT
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              inc,
   input  logic                              dec,
   output logic [$clog2(CAPACITY+1)-1:0]     count,
   output logic                              full,
   output logic                              empty
);

   localparam int CNT_W = $clog2(CAPACITY + 1);

   assign full  = (count == CNT_W'(CAPACITY));
   assign empty = (count == '0);

   // Simultaneous inc and dec cancel; the flags stop the count from passing
   // either bound even if a caller ignores them.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + CNT_W'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/parking_sensor_driver.sv
// Photo-beam stimulus engine for the parking-lot gate. Accepts one car
// request at a time, plays the four-phase a/b pattern for enter or exit,
// holds a quiet gap, and tracks lot occupancy, refusing requests that would
// overfill or underflow the lot.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready is combinational from state)
//   req_dir             - 0 = enter, 1 = exit (sampled only at handshake)
//   req_dwell           - cycles each beam phase is held, 0 behaves as 1
//   a, b                - outer / inner beam, registered
//   busy                - sequence or gap in progress
//   done                - one-cycle pulse as the last beam phase ends
//   rej                 - one-cycle pulse after a refused request
//   count               - modelled occupancy
module parking_sensor_driver
   import parking_pkg::*;
#(
   parameter int CAPACITY   = CAPACITY_DEFAULT,
   parameter int DWELL_W    = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   input  logic                          req_dir,
   input  logic [DWELL_W-1:0]            req_dwell,
   output logic                          req_ready,
   output logic                          a,
   output logic                          b,
   output logic                          busy,
   output logic                          done,
   output logic                          rej,
   output logic [$clog2(CAPACITY+1)-1:0] count
);

   localparam int GAP_W = 8;

   state_t               state;
   logic                 dir_q;
   logic [DWELL_W-1:0]   reload_q;
   logic [DWELL_W-1:0]   dwell_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [DWELL_W-1:0]   dwell_m1;
   logic                 full;
   logic                 empty;
   logic                 handshake;
   logic                 refuse;
   logic                 phase_end;
   logic                 car_passed;

   // NOTE: req_ready must not look at req_valid, otherwise a valid-waits-for-
   // ready source upstream would form a combinational loop.
   assign req_ready  = (state == IDLE) && !reset;
   assign handshake  = req_valid && req_ready;
   assign refuse     = handshake &&
                       (((req_dir == DIR_ENTER) && full) ||
                        ((req_dir == DIR_EXIT)  && empty));
   // The dwell counter holds "cycles left minus one", so a zero dwell request
   // loads the same value as dwell = 1.
   assign dwell_m1   = (req_dwell == '0) ? '0 : req_dwell - DWELL_W'(1);
   assign phase_end  = (dwell_cnt == '0);
   assign car_passed = (state == PH3) && phase_end;

   parking_occupancy_counter #(
      .CAPACITY (CAPACITY)
   ) u_occupancy (
      .clk   (clk),
      .reset (reset),
      .inc   (car_passed && (dir_q == DIR_ENTER)),
      .dec   (car_passed && (dir_q == DIR_EXIT)),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         {a, b}    <= AB_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rej       <= 1'b0;
         dir_q     <= DIR_ENTER;
         reload_q  <= '0;
         dwell_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         done <= 1'b0;
         rej  <= 1'b0;
         case (state)
            IDLE: begin
               if (refuse) begin
                  rej <= 1'b1;
               end else if (handshake) begin
                  dir_q     <= req_dir;
                  reload_q  <= dwell_m1;
                  dwell_cnt <= dwell_m1;
                  {a, b}    <= phase_ab(req_dir, PH1);
                  busy      <= 1'b1;
                  state     <= PH1;
               end
            end
            PH1: begin
               if (phase_end) begin
                  {a, b}    <= phase_ab(dir_q, PH2);
                  dwell_cnt <= reload_q;
                  state     <= PH2;
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            PH2: begin
               if (phase_end) begin
                  {a, b}    <= phase_ab(dir_q, PH3);
                  dwell_cnt <= reload_q;
                  state     <= PH3;
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            PH3: begin
               // The occupancy counter updates on this same edge via car_passed.
               if (phase_end) begin
                  {a, b}  <= AB_IDLE;
                  done    <= 1'b1;
                  gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                  state   <= GAP;
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               {a, b} <= AB_IDLE;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parking_sensor_driver.sv
// Directed testbench for parking_sensor_driver (CAPACITY=16, DWELL_W=8,
// GAP_CYCLES=4). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so each sample shows the effect of the edge
// just taken.
module tb_parking_sensor_driver;

   localparam int  CAP     = 16;
   localparam int  GAP     = 4;
   localparam logic ENTER  = 1'b0;
   localparam logic EXIT   = 1'b1;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_dir;
   logic [7:0] req_dwell;
   logic       req_ready;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       rej;
   logic [4:0] count;

   int checks;
   int errors;
   int model_count;
   int accepted_enter;
   int accepted_exit;
   int done_seen;
   int ups_seen;
   int downs_seen;
   logic [4:0] prev_count;
   logic       prev_reset;

   // Expected beam patterns {a,b} per direction and phase.
   logic [1:0] ph_tab [2][3] = '{'{2'b10, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b10}};

   parking_sensor_driver #(
      .CAPACITY   (CAP),
      .DWELL_W    (8),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_dir   (req_dir),
      .req_dwell (req_dwell),
      .req_ready (req_ready),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .rej       (rej),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Detector-side loopback: count done pulses and single-step count moves.
   initial begin
      done_seen  = 0;
      ups_seen   = 0;
      downs_seen = 0;
      prev_count = '0;
      prev_reset = 1'b1;
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
      if (!prev_reset && count === prev_count + 5'd1) ups_seen++;
      if (!prev_reset && count === prev_count - 5'd1) downs_seen++;
      prev_count = count;
      prev_reset = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      step();
      reset = 1'b0;
      model_count = 0;
   endtask

   // One accepted request, checked every cycle from the handshake until the
   // block is back in IDLE. Inputs are scrambled after the handshake.
   task automatic drive_car(input string name, input logic dir, input logic [7:0] dwell);
      int d;
      int total;
      logic [1:0] exp_ab;
      logic [5:0] exp_vec;
      logic [4:0] exp_cnt;
      d = (dwell == 8'd0) ? 1 : int'(dwell);
      total = 3 * d + GAP;
      req_valid = 1'b1;
      req_dir   = dir;
      req_dwell = dwell;
      step();
      req_valid = 1'b0;
      req_dir   = ~dir;
      req_dwell = 8'hff;
      for (int k = 0; k <= total; k++) begin
         exp_ab  = (k < 3 * d) ? ph_tab[int'(dir)][k / d] : 2'b00;
         exp_vec = {exp_ab, (k == 3 * d), (k < total), (k == total), 1'b0};
         exp_cnt = (k < 3 * d) ? 5'(model_count)
                               : 5'(dir == ENTER ? model_count + 1 : model_count - 1);
         checks++;
         if ({a, b, done, busy, req_ready, rej} !== exp_vec) begin
            errors++;
            $display("FAIL %s cycle %0d {a,b,done,busy,ready,rej}: got %b expected %b",
                     name, k, {a, b, done, busy, req_ready, rej}, exp_vec);
         end
         checks++;
         if (count !== exp_cnt) begin
            errors++;
            $display("FAIL %s cycle %0d count: got %0d expected %0d", name, k, count, exp_cnt);
         end
         if (k < total) step();
      end
      if (dir == ENTER) begin
         model_count++;
         accepted_enter++;
      end else begin
         model_count--;
         accepted_exit++;
      end
   endtask

   // Request expected to be refused: rej one cycle later, nothing else moves.
   task automatic refuse_car(input string name, input logic dir);
      logic [4:0] exp_cnt;
      exp_cnt   = 5'(model_count);
      req_valid = 1'b1;
      req_dir   = dir;
      req_dwell = 8'd2;
      step();
      req_valid = 1'b0;
      checks++;
      if ({a, b, done, busy, req_ready, rej} !== 6'b000011) begin
         errors++;
         $display("FAIL %s rej cycle: got %b expected 000011", name,
                  {a, b, done, busy, req_ready, rej});
      end
      checks++;
      if (count !== exp_cnt) begin
         errors++;
         $display("FAIL %s count: got %0d expected %0d", name, count, exp_cnt);
      end
      step();
      checks++;
      if ({a, b, done, busy, req_ready, rej} !== 6'b000010) begin
         errors++;
         $display("FAIL %s after rej: got %b expected 000010", name,
                  {a, b, done, busy, req_ready, rej});
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_dir   = ENTER;
      req_dwell = 8'd3;
      step();
      step();
      checks++;
      if ({a, b, done, busy, req_ready, rej} !== 6'b000000 || count !== 5'd0) begin
         errors++;
         $display("FAIL reset_state: got %b count %0d expected 000000 count 0",
                  {a, b, done, busy, req_ready, rej}, count);
      end
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release ready: got %b expected 1", req_ready);
      end
      model_count = 0;
   endtask

   task automatic test_exit_empty();
      refuse_car("exit_empty", EXIT);
   endtask

   task automatic test_enter_basic();
      drive_car("enter_dwell3", ENTER, 8'd3);
   endtask

   task automatic test_fill_reject();
      do_reset();
      for (int i = 0; i < CAP; i++) drive_car("fill", ENTER, 8'd1);
      refuse_car("enter_full", ENTER);
      drive_car("exit_from_full", EXIT, 8'd1);
   endtask

   task automatic test_dwell_zero();
      drive_car("exit_dwell0", EXIT, 8'd0);
      drive_car("exit_dwell1", EXIT, 8'd1);
   endtask

   task automatic test_back_to_back();
      int d;
      int total;
      int guard;
      logic [1:0] exp_ab;
      logic [5:0] exp_vec;
      do_reset();
      d = 2;
      total = 3 * d + GAP;
      req_valid = 1'b1;
      req_dir   = ENTER;
      req_dwell = 8'd2;
      step();
      for (int k = 0; k <= total; k++) begin
         exp_ab  = (k < 3 * d) ? ph_tab[0][k / d] : 2'b00;
         exp_vec = {exp_ab, (k == 3 * d), (k < total), (k == total), 1'b0};
         checks++;
         if ({a, b, done, busy, req_ready, rej} !== exp_vec) begin
            errors++;
            $display("FAIL b2b cycle %0d: got %b expected %b", k,
                     {a, b, done, busy, req_ready, rej}, exp_vec);
         end
         step();
      end
      // Second handshake took place on the first IDLE cycle.
      req_valid = 1'b0;
      checks++;
      if ({a, b, busy, req_ready} !== 4'b1010 || count !== 5'd1) begin
         errors++;
         $display("FAIL b2b second_accept: got ab=%b busy=%b ready=%b count=%0d expected ab=10 busy=1 ready=0 count=1",
                  {a, b}, busy, req_ready, count);
      end
      guard = 0;
      while (req_ready !== 1'b1 && guard < 40) begin
         step();
         guard++;
      end
      checks++;
      if (req_ready !== 1'b1 || count !== 5'd2) begin
         errors++;
         $display("FAIL b2b second_finish: ready=%b count=%0d expected ready=1 count=2",
                  req_ready, count);
      end
      accepted_enter += 2;
      model_count = 2;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) drive_car("prefill5", ENTER, 8'd1);
      req_valid = 1'b1;
      req_dir   = ENTER;
      req_dwell = 8'd3;
      step();
      req_valid = 1'b0;
      step();
      step();
      step();
      checks++;
      if ({a, b} !== 2'b11 || count !== 5'd5) begin
         errors++;
         $display("FAIL rst_mid in_ph2: got ab=%b count=%0d expected ab=11 count=5", {a, b}, count);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({a, b, done, busy, rej} !== 5'b00000 || count !== 5'd0) begin
         errors++;
         $display("FAIL rst_mid forced: got %b count=%0d expected 00000 count=0",
                  {a, b, done, busy, rej}, count);
      end
      step();
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL rst_mid after: done=%b ready=%b count=%0d expected 0 1 0",
                  done, req_ready, count);
      end
      model_count = 0;
   endtask

   task automatic test_loopback();
      step();
      checks++;
      if (done_seen !== accepted_enter + accepted_exit) begin
         errors++;
         $display("FAIL loopback done_pulses: got %0d expected %0d", done_seen,
                  accepted_enter + accepted_exit);
      end
      checks++;
      if (ups_seen !== accepted_enter || downs_seen !== accepted_exit) begin
         errors++;
         $display("FAIL loopback inc/dec: got %0d/%0d expected %0d/%0d",
                  ups_seen, downs_seen, accepted_enter, accepted_exit);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      model_count    = 0;
      accepted_enter = 0;
      accepted_exit  = 0;
      reset          = 1'b1;
      req_valid      = 1'b0;
      req_dir        = ENTER;
      req_dwell      = 8'd0;

      test_reset();
      test_exit_empty();
      test_enter_basic();
      test_fill_reject();
      test_dwell_zero();
      test_back_to_back();
      test_reset_mid();
      test_loopback();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
